// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS datapath.
// Decodes the latched opcode and steps each instruction through the
// fetch/decode/execute/memory/writeback states. All outputs are Moore,
// decoded from the current state. Zero only affects PCEn in BRANCH.
// Optional feature: define JAL_EN to add the JAL state. When JAL_EN is
// undefined, opcode 000011 is treated as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef JAL_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11
`ifdef JAL_EN
    , S_JAL    = 4'd12
`endif
  } state_t;

  state_t state_q, state_d;

  // Ungated control values decoded from the current state
  logic       pcwrite, branch, branchne;
  logic       iord, memread, memwrite, irwrite, memtoreg, regwrite;
  logic       alusrca, extop, illegal;
  logic [1:0] regdst, alusrcb, pcsource;
  logic [2:0] aluop;

  // State register: synchronous active-low reset returns to FETCH
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d  = S_FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    extop    = 1'b0;
    illegal  = 1'b0;
    regdst   = 2'b00;
    alusrcb  = 2'b00;
    pcsource = 2'b00;
    aluop    = 3'b000;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        aluop   = 3'b100;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = 3'b100;
        case (Opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:  state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
`ifdef JAL_EN
          OP_JAL:                            state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        extop   = 1'b1;
        aluop   = 3'b100;
        if (Opcode == OP_LW)      state_d = S_MEMREAD;
        else if (Opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 3'b111;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 3'b001;
        branch   = 1'b1;
        branchne = (Opcode == OP_BNE);
        pcsource = 2'b01;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (Opcode)
          OP_ORI:  aluop = 3'b101;
          OP_ANDI: aluop = 3'b110;
          OP_LUI:  aluop = 3'b011;
          default: begin
            aluop = 3'b100;
            extop = 1'b1;
          end
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        state_d  = S_FETCH;
      end
`ifdef JAL_EN
      // Link value is PC+4 already held in PC, passed through as PC + 0
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        aluop    = 3'b100;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Output gating: everything reads 0 while reset is held low
  always_comb begin
    PCEn     = reset & (pcwrite | (branch & (Zero ^ branchne)));
    IorD     = reset & iord;
    MemRead  = reset & memread;
    MemWrite = reset & memwrite;
    IRWrite  = reset & irwrite;
    MemtoReg = reset & memtoreg;
    RegDst   = reset ? regdst   : 2'b00;
    RegWrite = reset & regwrite;
    ALUSrcA  = reset & alusrca;
    ALUSrcB  = reset ? alusrcb  : 2'b00;
    ExtOp    = reset & extop;
    PCSource = reset ? pcsource : 2'b00;
    ALUOp    = reset ? aluop    : 3'b000;
    Illegal  = reset & illegal;
    State    = reset ? state_q  : 4'd0;
  end

endmodule
